// File: rtl/trace_ring_buffer.sv
// Circular trace store in front of a dual-port block RAM: port A writes, port B reads.
// Read issue is credit-limited so the output skid FIFO always has room for every read in flight.
module trace_ring_buffer #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 8,
   parameter int RAM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH:0]   level,
   output logic [ADDR_WIDTH-1:0] ram_addr_a,
   output logic [DATA_WIDTH-1:0] ram_data_a,
   output logic                  ram_wren_a,
   output logic [ADDR_WIDTH-1:0] ram_addr_b,
   output logic [DATA_WIDTH-1:0] ram_data_b,
   output logic                  ram_wren_b,
   output logic                  ram_clken,
   input  logic [DATA_WIDTH-1:0] ram_q_b
);

   localparam int DEPTH      = 2 ** ADDR_WIDTH;
   localparam int SKID_DEPTH = RAM_LATENCY + 1;
   localparam int CW         = $clog2(SKID_DEPTH + 1);
   localparam int SW         = $clog2(SKID_DEPTH);

   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_issue_ptr;
   logic [ADDR_WIDTH:0]   rd_retire_ptr;
   logic [CW-1:0]         credits;
   logic [RAM_LATENCY-1:0] vpipe;

   logic [DATA_WIDTH-1:0] skid_mem [SKID_DEPTH];
   logic [SW-1:0]         skid_head;
   logic [SW-1:0]         skid_tail;
   logic [CW-1:0]         skid_count;

   logic clr;
   logic full;
   logic wr_en;
   logic issue;
   logic retire;
   logic pop;

   function automatic logic [SW-1:0] skid_inc(input logic [SW-1:0] p);
      return (p == SW'(SKID_DEPTH - 1)) ? '0 : p + SW'(1);
   endfunction

   always_comb begin
      clr       = reset | flush;
      level     = wr_ptr - rd_retire_ptr;
      full      = (level == (ADDR_WIDTH+1)'(DEPTH));
      in_ready  = !full && !clr;
      wr_en     = in_valid && in_ready;
      out_valid = (skid_count != '0);
      out_data  = out_valid ? skid_mem[skid_head] : '0;
      pop       = out_valid && out_ready;
      // A pop in this cycle frees a skid slot, so it may fund an issue in the same cycle.
      issue     = !clr && (rd_issue_ptr != wr_ptr) && ((credits != '0) || pop);
      retire    = vpipe[RAM_LATENCY-1] && !clr;
   end

   always_comb begin
      ram_addr_a = wr_ptr[ADDR_WIDTH-1:0];
      ram_data_a = in_data;
      ram_wren_a = wr_en;
      ram_addr_b = rd_issue_ptr[ADDR_WIDTH-1:0];
      ram_data_b = '0;
      ram_wren_b = 1'b0;
      ram_clken  = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr        <= '0;
         rd_issue_ptr  <= '0;
         rd_retire_ptr <= '0;
         credits       <= CW'(SKID_DEPTH);
         vpipe         <= '0;
         skid_head     <= '0;
         skid_tail     <= '0;
         skid_count    <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;
         if (issue)
            rd_issue_ptr <= rd_issue_ptr + 1'b1;
         vpipe[0] <= issue;
         for (int unsigned i = 1; i < RAM_LATENCY; i++)
            vpipe[i] <= vpipe[i-1];
         if (retire) begin
            rd_retire_ptr <= rd_retire_ptr + 1'b1;
            skid_tail     <= skid_inc(skid_tail);
         end
         if (pop)
            skid_head <= skid_inc(skid_head);
         skid_count <= skid_count + CW'(retire) - CW'(pop);
         credits    <= credits - CW'(issue) + CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (retire)
         skid_mem[skid_tail] <= ram_q_b;
   end

endmodule

// File: tb/tb_trace_ring_buffer.sv
// Directed bench for trace_ring_buffer: one DUT at RAM_LATENCY=1 and one at RAM_LATENCY=3,
// each attached to a behavioural dual-port RAM of matching latency.
module tb_trace_ring_buffer;

   localparam int DW = 32;
   localparam int AW = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic          f1, iv1, ir1, ov1, or1, wa1, wb1, ck1;
   logic [DW-1:0] id1, od1, da1, db1, q1;
   logic [AW:0]   lv1;
   logic [AW-1:0] aa1, ab1;

   logic          f3, iv3, ir3, ov3, or3, wa3, wb3, ck3;
   logic [DW-1:0] id3, od3, da3, db3, q3;
   logic [AW:0]   lv3;
   logic [AW-1:0] aa3, ab3;

   trace_ring_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_LATENCY(1)) u_dut1 (
      .clk(clk), .reset(reset), .flush(f1),
      .in_valid(iv1), .in_data(id1), .in_ready(ir1),
      .out_valid(ov1), .out_data(od1), .out_ready(or1), .level(lv1),
      .ram_addr_a(aa1), .ram_data_a(da1), .ram_wren_a(wa1),
      .ram_addr_b(ab1), .ram_data_b(db1), .ram_wren_b(wb1),
      .ram_clken(ck1), .ram_q_b(q1)
   );

   trace_ring_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_LATENCY(3)) u_dut3 (
      .clk(clk), .reset(reset), .flush(f3),
      .in_valid(iv3), .in_data(id3), .in_ready(ir3),
      .out_valid(ov3), .out_data(od3), .out_ready(or3), .level(lv3),
      .ram_addr_a(aa3), .ram_data_a(da3), .ram_wren_a(wa3),
      .ram_addr_b(ab3), .ram_data_b(db3), .ram_wren_b(wb3),
      .ram_clken(ck3), .ram_q_b(q3)
   );

   // Behavioural RAMs: read data appears RAM_LATENCY cycles after the address.
   logic [DW-1:0] mem1 [16];
   logic [DW-1:0] mem3 [16];
   logic [DW-1:0] q3p  [3];

   always @(posedge clk) begin
      if (wa1) mem1[aa1] <= da1;
      q1 <= mem1[ab1];
      if (wa3) mem3[aa3] <= da3;
      q3p[0] <= mem3[ab3];
      q3p[1] <= q3p[0];
      q3p[2] <= q3p[1];
   end
   assign q3 = q3p[2];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   int accepted;
   int sent, got;
   logic stall;
   logic [DW-1:0] held;

   initial begin
      f1 = 0; iv1 = 0; id1 = '0; or1 = 0;
      f3 = 0; iv3 = 0; id3 = '0; or3 = 0;
      reset = 1;

      // Reset held over two checked cycles
      for (int r = 0; r < 2; r++) begin
         @(negedge clk);
         check("rst in_ready", ir1, 0);
         check("rst clken", ck1, 1);
         check("rst wren_b", wb1, 0);
         check("rst data_b", db1, 0);
         check("rst wren_a", wa1, 0);
         check("rst out_valid", ov1, 0);
         check("rst out_data", od1, 0);
         check("rst level", lv1, 0);
         check("rst addr_a", aa1, 0);
         check("rst addr_b", ab1, 0);
         check("rst3 in_ready", ir3, 0);
         check("rst3 clken", ck3, 1);
         next_cycle();
      end
      reset = 0;
      @(negedge clk);
      check("post rst in_ready", ir1, 1);
      check("post rst out_valid", ov1, 0);
      check("post rst level", lv1, 0);
      check("post rst clken", ck1, 1);
      check("post rst3 in_ready", ir3, 1);
      next_cycle();

      // Single write, latency to output
      iv1 = 1; id1 = 32'hA5; or1 = 1;
      @(negedge clk);
      check("A wren_a", wa1, 1);
      check("A addr_a", aa1, 0);
      check("A data_a", da1, 32'hA5);
      check("A c0 out_valid", ov1, 0);
      next_cycle();
      iv1 = 0;
      @(negedge clk);
      check("A c1 out_valid", ov1, 0);
      check("A c1 addr_b", ab1, 0);
      check("A c1 level", lv1, 1);
      next_cycle();
      @(negedge clk);
      check("A c2 out_valid", ov1, 0);
      check("A c2 level", lv1, 1);
      next_cycle();
      @(negedge clk);
      check("A c3 out_valid", ov1, 1);
      check("A c3 out_data", od1, 32'hA5);
      check("A c3 level", lv1, 0);
      next_cycle();
      @(negedge clk);
      check("A c4 out_valid", ov1, 0);
      next_cycle();

      // 40-vector stream, write pointer starts at 1
      for (int c = 0; c < 46; c++) begin
         iv1 = (c < 40);
         id1 = c;
         @(negedge clk);
         if (c < 40) begin
            check("B in_ready", ir1, 1);
            check("B addr_a", aa1, (1 + c) % 16);
         end
         if (c >= 1 && c <= 40)
            check("B addr_b", ab1, c % 16);
         check("B out_valid", ov1, (c >= 3 && c < 43));
         if (c >= 3 && c < 43)
            check("B out_data", od1, c - 3);
         next_cycle();
      end
      @(negedge clk);
      check("B level", lv1, 0);
      next_cycle();

      // Fill with out_ready low: ring holds DEPTH, skid holds two more
      or1 = 0;
      accepted = 0;
      for (int c = 0; c < 24; c++) begin
         iv1 = 1;
         id1 = 100 + accepted;
         @(negedge clk);
         if (ir1) accepted++;
         next_cycle();
      end
      iv1 = 0;
      @(negedge clk);
      check("C accepted", accepted, 18);
      check("C level", lv1, 16);
      check("C in_ready", ir1, 0);
      check("C out_valid", ov1, 1);
      check("C out_data", od1, 100);
      next_cycle();
      for (int i = 0; i < 18; i++) begin
         or1 = 1;
         @(negedge clk);
         check("C drain valid", ov1, 1);
         check("C drain data", od1, 100 + i);
         if (i < 2)
            check("C in_ready low", ir1, 0);
         if (i == 2)
            check("C in_ready back", ir1, 1);
         next_cycle();
      end
      @(negedge clk);
      check("C empty valid", ov1, 0);
      check("C empty level", lv1, 0);
      next_cycle();

      // Random out_ready, RAM_LATENCY=1
      sent = 0; got = 0; stall = 0; held = '0;
      for (int k = 0; k < 3000 && got < 200; k++) begin
         or1 = 1'($urandom_range(0, 1));
         iv1 = (sent < 200);
         id1 = 32'hC000_0000 + sent;
         @(negedge clk);
         if (iv1 && ir1) sent++;
         if (stall) begin
            check("D1 held valid", ov1, 1);
            check("D1 held data", od1, held);
         end
         if (ov1 && or1) begin
            check("D1 data", od1, 32'hC000_0000 + got);
            got++;
         end
         stall = ov1 && !or1;
         held = od1;
         next_cycle();
      end
      check("D1 count", got, 200);
      iv1 = 0; or1 = 1;
      next_cycle();
      next_cycle();
      @(negedge clk);
      check("D1 no extra", ov1, 0);
      check("D1 level", lv1, 0);
      next_cycle();

      // Random out_ready, RAM_LATENCY=3
      sent = 0; got = 0; stall = 0; held = '0;
      for (int k = 0; k < 3000 && got < 200; k++) begin
         or3 = 1'($urandom_range(0, 1));
         iv3 = (sent < 200);
         id3 = 32'hD000_0000 + sent;
         @(negedge clk);
         if (iv3 && ir3) sent++;
         if (stall) begin
            check("D3 held valid", ov3, 1);
            check("D3 held data", od3, held);
         end
         if (ov3 && or3) begin
            check("D3 data", od3, 32'hD000_0000 + got);
            got++;
         end
         stall = ov3 && !or3;
         held = od3;
         next_cycle();
      end
      check("D3 count", got, 200);
      iv3 = 0; or3 = 1;
      for (int c = 0; c < 6; c++) next_cycle();
      @(negedge clk);
      check("D3 no extra", ov3, 0);
      check("D3 level", lv3, 0);
      next_cycle();

      // Flush with three reads in flight and one entry in the skid FIFO
      or3 = 0;
      for (int c = 0; c < 5; c++) begin
         iv3 = 1;
         id3 = 32'h300 + c;
         @(negedge clk);
         check("E write", wa3, 1);
         next_cycle();
      end
      iv3 = 1; f3 = 1;
      @(negedge clk);
      check("E flush in_ready", ir3, 0);
      check("E flush wren_a", wa3, 0);
      check("E pre valid", ov3, 1);
      check("E pre level", lv3, 4);
      next_cycle();
      f3 = 0; iv3 = 0; or3 = 1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("E quiet valid", ov3, 0);
         if (c == 0)
            check("E level", lv3, 0);
         next_cycle();
      end
      iv3 = 1; id3 = 32'h5A;
      @(negedge clk);
      check("E new addr_a", aa3, 0);
      check("E new wren_a", wa3, 1);
      next_cycle();
      iv3 = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("E wait valid", ov3, 0);
         next_cycle();
      end
      @(negedge clk);
      check("E readback valid", ov3, 1);
      check("E readback data", od3, 32'h5A);
      next_cycle();
      @(negedge clk);
      check("E after valid", ov3, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
